// File: rtl/core_wb_pkg.sv
// core_wb_pkg: shared types and constants for the core-to-Wishbone bridge.
//   state_t       : bridge FSM states (IDLE, BUSY, FLUSH)
//   DEF_*         : default parameter values for the bridge
//   cnt_width()   : bit width needed to hold a count of 0..max_val
package core_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 255;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/core_wb_watchdog.sv
// core_wb_watchdog: counts consecutive enabled cycles without a clear and
// pulses expire on the TIMEOUT_CYCLES-th such cycle.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : count only while high (bridge is BUSY)
//   clear     : restart the count (response or new grant this cycle)
//   expire    : one-cycle pulse when the idle budget is used up
module core_wb_watchdog import core_wb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST_C = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ONE_C  = TW'(1);

  logic [TW-1:0] count_r;

  // The count holds the number of idle cycles already seen, so the current
  // cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign expire = enable & ~clear & (count_r == LAST_C);

  // Idle-cycle counter; restarts whenever the bridge is not waiting idly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (~enable | clear | expire) begin
      count_r <= {TW{1'b0}};
    end else begin
      count_r <= count_r + ONE_C;
    end
  end

endmodule

// File: rtl/core_wb_pipe_bridge.sv
// core_wb_pipe_bridge: core bus slave to Wishbone B4 pipelined master.
// Up to MAX_OUTSTANDING transfers in flight, responses returned in order.
//   Core side : core_req/core_gnt/core_we/core_be/core_addr/core_wdata in,
//               core_rvalid/core_rdata/core_err out (registered).
//   WB side   : wb_cyc/wb_stb/wb_we/wb_sel/wb_adr/wb_dat_o out,
//               wb_dat_i/wb_ack/wb_err/wb_stall in.
//   clk, rst  : rising-edge clock, synchronous active-high reset.
// Optional watchdog: define CORE_WB_TIMEOUT_EN to abort a hung cycle after
// TIMEOUT_CYCLES idle cycles; outstanding transfers are then answered with
// core_err=1, one per cycle.
module core_wb_pipe_bridge import core_wb_pkg::*; #(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  output logic        core_gnt,
  output logic        core_rvalid,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          flush_s;
  logic          stb_s;
  logic          gnt_s;
  logic          resp_s;
  logic          expire_s;

  assign flush_s = (state_r == FLUSH);
  assign stb_s   = core_req & (cnt_r < MAX_C) & ~flush_s;
  assign gnt_s   = stb_s & ~wb_stall;
  // Acks with nothing outstanding are spurious and must not produce rvalid.
  assign resp_s  = (wb_ack | wb_err) & (cnt_r != ZERO_C) & ~flush_s;

  assign core_gnt = gnt_s;
  assign wb_stb   = stb_s;
  assign wb_cyc   = ~flush_s & (stb_s | (cnt_r != ZERO_C));
  assign wb_we    = core_we;
  assign wb_sel   = core_be;
  assign wb_adr   = core_addr;
  assign wb_dat_o = core_wdata;

`ifdef CORE_WB_TIMEOUT_EN
  core_wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (state_r == BUSY),
    .clear  (resp_s | gnt_s),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Outstanding count: +1 on grant, -1 on response, one per cycle in FLUSH.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush_s) begin
      if (cnt_r != ZERO_C) begin
        cnt_nxt_s = cnt_r - ONE_C;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (gnt_s & ~resp_s) begin
      cnt_nxt_s = cnt_r + ONE_C;
    end else if (resp_s & ~gnt_s) begin
      cnt_nxt_s = cnt_r - ONE_C;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Next-state logic; leaving BUSY for IDLE is keyed on the count draining.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_nxt_s == ZERO_C) begin
          state_nxt_s = IDLE;
        end else if (expire_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      FLUSH: begin
        if (cnt_nxt_s == ZERO_C) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and outstanding-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered response to the core; rdata keeps its last value between
  // responses, and a flushed transfer returns an error with stale rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
      core_rdata  <= 32'h0000_0000;
    end else if (flush_s && (cnt_r != ZERO_C)) begin
      core_rvalid <= 1'b1;
      core_err    <= 1'b1;
      core_rdata  <= core_rdata;
    end else if (resp_s) begin
      core_rvalid <= 1'b1;
      core_err    <= wb_err;
      core_rdata  <= wb_dat_i;
    end else begin
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
      core_rdata  <= core_rdata;
    end
  end

endmodule

// File: tb/tb_core_wb_pipe_bridge.sv
// tb_core_wb_pipe_bridge: directed bench for core_wb_pipe_bridge.
// A Wishbone slave model schedules acks from a per-transfer plan and pushes
// the expected core response into a scoreboard when the request is granted;
// the monitor pops and compares on every core_rvalid.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. The watchdog scenario is built only with
// CORE_WB_TIMEOUT_EN defined.
module tb_core_wb_pipe_bridge;
  import core_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_gnt;
  logic        core_rvalid;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  // slave model outputs and bench-driven spurious ack
  logic        ack_q = 1'b0;
  logic        err_q = 1'b0;
  logic [31:0] dat_q = 32'h0;
  logic        spur_ack;
  logic [31:0] spur_dat;

  assign wb_ack   = ack_q | spur_ack;
  assign wb_err   = err_q;
  assign wb_dat_i = spur_ack ? spur_dat : dat_q;

  int n_cmp = 0;
  int n_err = 0;
  int n_rv  = 0;
  int cyc   = 0;

  // mode: 0 = ack, 1 = err only, 2 = ack and err together
  typedef struct {int delay; logic [31:0] dat; int mode; bit hang;} plan_t;
  typedef struct {int due; logic [31:0] dat; int mode;} pend_t;
  typedef struct {logic [31:0] dat; logic err; bit flush;} exp_t;

  plan_t plan_q[$];
  pend_t pend_q[$];
  exp_t  exp_q[$];
  int    ack_cyc_q[$];

  core_wb_pipe_bridge #(
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_adr     (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_stall   (wb_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input int d, input logic [31:0] dat, input int mode, input bit hang);
    plan_t p;
    p.delay = d; p.dat = dat; p.mode = mode; p.hang = hang;
    plan_q.push_back(p);
  endtask

  // Issue n requests back to back (no stall); leaves core_req high.
  task automatic issue(input int n, input logic we, input logic [31:0] base, input string tag);
    int idx = 0;
    for (int t = 0; t < 40 && idx < n; t++) begin
      step();
      core_req  = 1'b1;
      core_we   = we;
      core_addr = base + 32'(idx * 4);
      @(negedge clk);
      if (core_gnt) idx++;
    end
    chk(tag, 32'(idx), 32'(n));
  endtask

  task automatic drain(input int maxc, input string tag);
    for (int t = 0; t < maxc && exp_q.size() != 0; t++) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Slave model + response monitor.
  always begin
    pend_t pe;
    plan_t p;
    exp_t  e;
    int    a;
    @(negedge clk);
    if (rst) begin
      plan_q.delete(); pend_q.delete(); exp_q.delete(); ack_cyc_q.delete();
    end else begin
      if (core_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_rv++;
          chk("rsp_err", 32'(core_err), 32'(e.err));
          if (!e.flush) begin
            chk("rsp_rdata", core_rdata, e.dat);
            a = ack_cyc_q.pop_front();
            chk("rsp_latency", 32'(cyc), 32'(a + 1));
          end
        end
      end
      if (core_gnt) begin
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else begin p.delay = 1; p.dat = core_addr ^ 32'h5A5A_5A5A; p.mode = 0; p.hang = 1'b0; end
        if (p.hang) begin
          e.dat = 32'h0; e.err = 1'b1; e.flush = 1'b1;
        end else begin
          pe.due = cyc + p.delay; pe.dat = p.dat; pe.mode = p.mode;
          pend_q.push_back(pe);
          e.dat = p.dat; e.err = (p.mode != 0); e.flush = 1'b0;
        end
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      pe = pend_q.pop_front();
      ack_q = (pe.mode != 1);
      err_q = (pe.mode != 0);
      dat_q = pe.dat;
      ack_cyc_q.push_back(cyc);
    end else begin
      ack_q = 1'b0;
      err_q = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int idx;
    int mcnt;
    int rv0;
    int exp_g;
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_be = 4'hF;
    core_addr = 32'h0; core_wdata = 32'h0; wb_stall = 1'b0;
    spur_ack = 1'b0; spur_dat = 32'h0;

    // ---- reset state
    step(); step();
    @(negedge clk);
    chk("rst_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_err",    32'(core_err), 32'd0);
    chk("rst_rdata",  core_rdata, 32'h0);
    chk("rst_cyc",    32'(wb_cyc), 32'd0);
    chk("rst_stb",    32'(wb_stb), 32'd0);
    chk("rst_cnt",    32'(dut.cnt_r), 32'd0);
    step();
    rst = 1'b0;

    // ---- single read, ack two cycles after grant
    plan(2, 32'hDEAD_BEEF, 0, 1'b0);
    step();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_1000; core_be = 4'b1111;
    @(negedge clk);
    chk("rd_gnt", 32'(core_gnt), 32'd1);
    chk("rd_stb", 32'(wb_stb), 32'd1);
    chk("rd_adr", wb_adr, 32'h0000_1000);
    chk("rd_we",  32'(wb_we), 32'd0);
    chk("rd_sel", 32'(wb_sel), 32'hF);
    step();
    core_req = 1'b0;
    @(negedge clk);
    chk("rd_cyc_busy", 32'(wb_cyc), 32'd1);
    drain(10, "rd_drain");
    @(negedge clk);
    chk("rd_cyc_after", 32'(wb_cyc), 32'd0);
    chk("rd_rdata_hold", core_rdata, 32'hDEAD_BEEF);
    chk("rd_state_idle", 32'(dut.state_r), 32'(IDLE));

    // ---- burst of 6 writes, stall in cycles 1-2, acks 3 cycles late
    for (int i = 0; i < 6; i++) plan(3, 32'hB000_0000 + 32'(i), 0, 1'b0);
    rv0 = n_rv;
    idx = 0;
    for (int t = 0; t < 30 && idx < 6; t++) begin
      step();
      wb_stall   = (t == 1 || t == 2);
      core_req   = 1'b1;
      core_we    = 1'b1;
      core_be    = 4'b0011;
      core_addr  = 32'h0000_2000 + 32'(idx * 4);
      core_wdata = 32'hC0DE_0000 + 32'(idx);
      @(negedge clk);
      if (wb_stall) chk("wr_gnt_stalled", 32'(core_gnt), 32'd0);
      chk("wr_cnt_le_max", 32'(dut.cnt_r <= 3'd4), 32'd1);
      chk("wr_dat_o", wb_dat_o, 32'hC0DE_0000 + 32'(idx));
      if (core_gnt) idx++;
    end
    chk("wr_all_granted", 32'(idx), 32'd6);
    step();
    core_req = 1'b0; wb_stall = 1'b0; core_be = 4'hF;
    drain(30, "wr_drain");
    chk("wr_rvalid_count", 32'(n_rv - rv0), 32'd6);

    // ---- fill to 4, then grants coinciding with acks
    for (int i = 0; i < 7; i++) plan(6, 32'h3000_0000 + 32'(i), 0, 1'b0);
    mcnt = 0;
    idx = 0;
    for (int t = 0; t < 40 && idx < 7; t++) begin
      step();
      core_req = 1'b1; core_we = 1'b0;
      core_addr = 32'h0000_3000 + 32'(idx * 4);
      @(negedge clk);
      exp_g = (mcnt < 4) ? 1 : 0;
      chk("full_gnt", 32'(core_gnt), 32'(exp_g));
      chk("full_cnt", 32'(dut.cnt_r), 32'(mcnt));
      if (core_gnt) idx++;
      mcnt = mcnt + exp_g - (((wb_ack | wb_err) && mcnt != 0) ? 1 : 0);
    end
    chk("full_all_granted", 32'(idx), 32'd7);
    step();
    core_req = 1'b0;
    drain(40, "full_drain");

    // ---- error on the 2nd of 3 reads, then ack+err together
    plan(2, 32'h4000_0000, 0, 1'b0);
    plan(2, 32'h4000_0001, 1, 1'b0);
    plan(2, 32'h4000_0002, 0, 1'b0);
    plan(2, 32'h4000_0003, 2, 1'b0);
    issue(4, 1'b0, 32'h0000_4000, "err_issue");
    step();
    core_req = 1'b0;
    drain(20, "err_drain");

    // ---- spurious ack while idle
    step();
    spur_ack = 1'b1; spur_dat = 32'h1234_5678;
    @(negedge clk);
    chk("spur_cnt_during", 32'(dut.cnt_r), 32'd0);
    step();
    spur_ack = 1'b0;
    @(negedge clk);
    chk("spur_rvalid", 32'(core_rvalid), 32'd0);
    chk("spur_cnt", 32'(dut.cnt_r), 32'd0);
    chk("spur_rdata_hold", core_rdata, 32'h4000_0003);

`ifdef CORE_WB_TIMEOUT_EN
    // ---- watchdog: 3 hung reads, flush after 8 idle cycles
    plan(0, 32'h0, 0, 1'b1);
    plan(0, 32'h0, 0, 1'b1);
    plan(0, 32'h0, 0, 1'b1);
    issue(3, 1'b0, 32'h0000_5000, "wd_issue");
    step();
    core_req = 1'b0;
    idx = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!wb_cyc) break;
      idx++;
    end
    chk("wd_idle_cycles", 32'(idx), 32'd8);
    chk("wd_state_flush", 32'(dut.state_r), 32'(FLUSH));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("wd_rvalid", 32'(core_rvalid), 32'd1);
      chk("wd_err", 32'(core_err), 32'd1);
    end
    @(negedge clk);
    chk("wd_state_idle", 32'(dut.state_r), 32'(IDLE));
    chk("wd_rvalid_end", 32'(core_rvalid), 32'd0);
`endif

    // ---- reset in the middle of a burst
    for (int i = 0; i < 3; i++) plan(3, 32'h6000_0000 + 32'(i), 0, 1'b0);
    issue(3, 1'b0, 32'h0000_6000, "rst_issue");
    step();
    core_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", 32'(core_rvalid), 32'd0);
    chk("midrst_cnt", 32'(dut.cnt_r), 32'd0);
    chk("midrst_cyc", 32'(wb_cyc), 32'd0);
    step();
    @(negedge clk);
    chk("midrst_rvalid_next", 32'(core_rvalid), 32'd0);
    chk("midrst_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
